// File: rtl/aho_pkg.sv
// Shared types and constants for the AHO display stage.
package aho_pkg;

   typedef logic [3:0] bcd_t;

   localparam int NUM_DIGITS = 4;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/aho_display_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes blank the digit.
module bcd_to_seg7
   import aho_pkg::*;
(
   input  bcd_t       bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         // NOTE: a full case with default keeps this purely combinational (no latch).
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/aho_display.sv
// AHO event tally (4-digit BCD, sticky overflow) driving a multiplexed 7-segment
// display from a per-frame snapshot so digits never change mid-scan.
module aho_display
   import aho_pkg::*;
#(
   parameter int SCAN_DIV = 16
)
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       AHO,
   input  logic       CLR,
   output logic [6:0] SEG,
   output logic [3:0] DIG,
   output logic       OVF
);

   localparam int              SC_W    = $clog2(SCAN_DIV);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

   logic [15:0]     tally;
   logic [15:0]     tally_inc;
   logic [15:0]     snap;
   logic [SC_W-1:0] sc;
   logic [1:0]      idx;
   logic            carry;
   logic            sc_wrap;
   logic            frame_end;
   bcd_t            cur_digit;

   // NOTE: carry is a blocking temporary that ripples through the loop; only
   // the final value leaves the block, so this stays combinational.
   always_comb begin
      tally_inc = tally;
      carry     = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (tally[4*i +: 4] == 4'd9) begin
               tally_inc[4*i +: 4] = 4'd0;
            end else begin
               tally_inc[4*i +: 4] = tally[4*i +: 4] + 4'd1;
               carry               = 1'b0;
            end
         end
      end
   end

   assign sc_wrap   = (sc == SC_LAST);
   assign frame_end = sc_wrap && (idx == 2'd3);

   // NOTE: non-blocking assignments so every register samples pre-edge values;
   // the snapshot therefore captures the tally without this edge's increment.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         tally <= '0;
         snap  <= '0;
         OVF   <= 1'b0;
         sc    <= '0;
         idx   <= '0;
      end else begin
         if (CLR) begin
            tally <= '0;
            OVF   <= 1'b0;
         end else if (AHO) begin
            tally <= tally_inc;
            if (carry) OVF <= 1'b1;
         end

         if (sc_wrap) begin
            sc  <= '0;
            idx <= idx + 2'd1;
         end else begin
            sc  <= sc + SC_W'(1);
         end

         if (frame_end) snap <= tally;
      end
   end

   assign cur_digit = snap[{idx, 2'b00} +: 4];
   assign DIG       = ~(4'b0001 << idx);

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (SEG)
   );

endmodule

// File: tb/tb_aho_display.sv
// Self-checking bench for aho_display: scoreboard of tally/OVF plus display checks.
module tb_aho_display;

   typedef struct {
      logic [15:0] tally;
      logic        ovf;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       aho;
   logic       clr;
   logic [6:0] seg;
   logic [3:0] dig;
   logic       ovf;

   int   tests  = 0;
   int   errors = 0;
   int   model_cnt = 0;
   logic model_ovf = 1'b0;
   exp_t sb[$];
   exp_t e;

   aho_display #(.SCAN_DIV(4)) dut (
      .CLK (clk),
      .RST (rst),
      .AHO (aho),
      .CLR (clr),
      .SEG (seg),
      .DIG (dig),
      .OVF (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[3:0]   = 4'(v % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[15:12] = 4'((v / 1000) % 10);
      return r;
   endfunction

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // One clocked cycle with the given inputs; the expected result goes onto the scoreboard.
   task automatic drive_cycle(input logic a, input logic c);
      aho = a;
      clr = c;
      if (c) begin
         model_cnt = 0;
         model_ovf = 1'b0;
      end else if (a) begin
         if (model_cnt == 9999) begin
            model_cnt = 0;
            model_ovf = 1'b1;
         end else begin
            model_cnt++;
         end
      end
      sb.push_back('{to_bcd(model_cnt), model_ovf});
      @(posedge clk);
      #1;
      aho = 1'b0;
      clr = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_dig(input logic [3:0] pat);
      int k = 0;
      while (dig !== pat && k < 200) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (dig !== pat) begin
         tests++;
         errors++;
         $display("FAIL wait_dig: DIG=%b never reached %b", dig, pat);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      aho = 1'b0;
      clr = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      tests += 3;
      if (dig !== 4'b1110) begin errors++; $display("FAIL reset_dig: got %b want 1110", dig); end
      if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b want 1000000", seg); end
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      for (int i = 1; i < 4; i++) begin
         idle(1);
         tests++;
         if (dig !== 4'b1110) begin errors++; $display("FAIL reset_hold%0d: DIG=%b want 1110", i, dig); end
      end
      idle(1);
      tests++;
      if (dig !== 4'b1101) begin errors++; $display("FAIL reset_advance: DIG=%b want 1101", dig); end
   endtask

   task automatic test_count_display;
      for (int i = 0; i < 12; i++) begin
         drive_cycle(1'b1, 1'b0);
         e = sb.pop_front();
         tests++;
         if (dut.tally !== e.tally) begin errors++; $display("FAIL count[%0d]: tally=%h want %h", i, dut.tally, e.tally); end
      end
      idle(32);
      wait_dig(4'b1110);
      tests++;
      if (seg !== seg_of(2)) begin errors++; $display("FAIL disp_d0: SEG=%b want %b", seg, seg_of(2)); end
      wait_dig(4'b1101);
      tests++;
      if (seg !== seg_of(1)) begin errors++; $display("FAIL disp_d1: SEG=%b want %b", seg, seg_of(1)); end
      wait_dig(4'b1011);
      tests++;
      if (seg !== seg_of(0)) begin errors++; $display("FAIL disp_d2: SEG=%b want %b", seg, seg_of(0)); end
      wait_dig(4'b0111);
      tests++;
      if (seg !== seg_of(0)) begin errors++; $display("FAIL disp_d3: SEG=%b want %b", seg, seg_of(0)); end
   endtask

   task automatic test_carry;
      drive_cycle(1'b0, 1'b1);
      e = sb.pop_front();
      tests++;
      if (dut.tally !== e.tally) begin errors++; $display("FAIL carry_clr: tally=%h want %h", dut.tally, e.tally); end
      for (int i = 0; i < 100; i++) begin
         drive_cycle(1'b1, 1'b0);
         e = sb.pop_front();
         tests++;
         if (dut.tally !== e.tally || ovf !== e.ovf) begin
            errors++;
            $display("FAIL carry[%0d]: tally=%h ovf=%b want %h %b", i, dut.tally, ovf, e.tally, e.ovf);
         end
      end
      tests++;
      if (dut.tally !== 16'h0100) begin errors++; $display("FAIL carry_final: tally=%h want 0100", dut.tally); end
   endtask

   task automatic test_overflow;
      drive_cycle(1'b0, 1'b1);
      void'(sb.pop_front());
      for (int i = 0; i < 10005; i++) begin
         drive_cycle(1'b1, 1'b0);
         e = sb.pop_front();
         tests++;
         if (dut.tally !== e.tally || ovf !== e.ovf) begin
            errors++;
            $display("FAIL ovf_run[%0d]: tally=%h ovf=%b want %h %b", i, dut.tally, ovf, e.tally, e.ovf);
         end
      end
      tests++;
      if (dut.tally !== 16'h0005 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_final: tally=%h ovf=%b want 0005 1", dut.tally, ovf);
      end
   endtask

   task automatic test_clear_priority;
      for (int i = 0; i < 37; i++) begin
         drive_cycle(1'b1, 1'b0);
         e = sb.pop_front();
         tests++;
         if (dut.tally !== e.tally || ovf !== e.ovf) begin
            errors++;
            $display("FAIL to42[%0d]: tally=%h ovf=%b want %h %b", i, dut.tally, ovf, e.tally, e.ovf);
         end
      end
      idle(32);
      wait_dig(4'b0111);
      wait_dig(4'b1110);
      drive_cycle(1'b1, 1'b1);
      e = sb.pop_front();
      tests++;
      if (dut.tally !== e.tally || ovf !== e.ovf) begin
         errors++;
         $display("FAIL clr_prio: tally=%h ovf=%b want %h %b", dut.tally, ovf, e.tally, e.ovf);
      end
      tests++;
      if (dig !== 4'b1110 || seg !== seg_of(2)) begin
         errors++;
         $display("FAIL clr_old_d0: DIG=%b SEG=%b want 1110 %b", dig, seg, seg_of(2));
      end
      wait_dig(4'b1101);
      tests++;
      if (seg !== seg_of(4)) begin errors++; $display("FAIL clr_old_d1: SEG=%b want %b", seg, seg_of(4)); end
      wait_dig(4'b1110);
      tests++;
      if (seg !== seg_of(0)) begin errors++; $display("FAIL clr_new_d0: SEG=%b want %b", seg, seg_of(0)); end
      wait_dig(4'b1101);
      tests++;
      if (seg !== seg_of(0)) begin errors++; $display("FAIL clr_new_d1: SEG=%b want %b", seg, seg_of(0)); end
   endtask

   task automatic test_reset_mid_frame;
      for (int i = 0; i < 307; i++) begin
         drive_cycle(1'b1, 1'b0);
         e = sb.pop_front();
         tests++;
         if (dut.tally !== e.tally) begin errors++; $display("FAIL to307[%0d]: tally=%h want %h", i, dut.tally, e.tally); end
      end
      wait_dig(4'b1011);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_cnt = 0;
      model_ovf = 1'b0;
      tests += 6;
      if (dig !== 4'b1110) begin errors++; $display("FAIL mid_rst_dig: got %b want 1110", dig); end
      if (seg !== 7'b1000000) begin errors++; $display("FAIL mid_rst_seg: got %b want 1000000", seg); end
      if (dut.sc !== '0) begin errors++; $display("FAIL mid_rst_sc: got %0d want 0", dut.sc); end
      if (dut.tally !== 16'h0000) begin errors++; $display("FAIL mid_rst_tally: got %h want 0000", dut.tally); end
      if (dut.snap !== 16'h0000) begin errors++; $display("FAIL mid_rst_snap: got %h want 0000", dut.snap); end
      if (ovf !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf: got %b want 0", ovf); end
   endtask

   initial begin
      test_reset();
      test_count_display();
      test_carry();
      test_overflow();
      test_clear_priority();
      test_reset_mid_frame();
      tests++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d entries left, want 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/aho_display.md
# aho_display

Display stage placed directly downstream of the AHO generator. Counts every clock cycle on which `AHO` is high into a 4-digit BCD tally, with a sticky overflow flag. Drives a time-multiplexed, active-low 4-digit 7-segment display from a per-frame snapshot of the tally, so a digit never changes value partway through a scan frame.

## Interface
- `SCAN_DIV`, default 16: clock cycles each digit is enabled. Legal range is 2 or more.
- `CLK` input 1: single clock. All state changes on the rising edge.
- `RST` input 1: reset, synchronous, active-low.
- `AHO` input 1: level input from the upstream AHO generator; each high cycle is one event.
- `CLR` input 1: synchronous clear of the tally and `OVF`, active-high.
- `SEG` output 7: segments {g,f,e,d,c,b,a}, active-low, for the currently selected digit.
- `DIG` output 4: digit enables, active-low, one-hot-low. `DIG[0]` is the least significant digit.
- `OVF` output 1: sticky; set when the tally wraps from 9999 to 0000.

## Operation
- Tally: four BCD digits, `d3..d0`, each 4 bits.
  - In a cycle with `AHO`=1 and `CLR`=0, the tally increments by 1 with a decimal carry chain (9→0 carries into the next digit).
  - 9999 + 1 gives 0000 and sets `OVF`.
  - Digit values are never outside 0..9.
- Priority each cycle: `RST`=0 first, then `CLR`=1, then `AHO`=1.
  - `CLR` together with `AHO` gives tally 0000 and `OVF`=0. The `AHO` event is dropped.
- `OVF` stays at 1 until `RST` or `CLR`. Further wraps keep it at 1.
- Scan divider `sc`, range 0..SCAN_DIV-1:
  - Increments every cycle.
  - When `sc`=SCAN_DIV-1, `sc` returns to 0 and digit index `idx` (2 bits) advances 0→1→2→3→0.
- Snapshot: a 16-bit register `snap`.
  - It loads the registered tally value on the edge where `idx` goes 3→0. The load does not include an increment occurring on that same edge.
  - One frame is 4·SCAN_DIV cycles.
- Outputs:
  - `DIG` = ~(1 << `idx`).
  - `SEG` = decode(`snap` digit `idx`).
  - Both are combinational from registers only, with no input-to-output path.
- Decode (active-low g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - There is no leading-zero blanking.
- Reset values: tally 0000, `snap` 0000, `OVF` 0, `sc` 0, `idx` 0, so `DIG`=1110 and `SEG`=1000000.

## Timing
- Latency from `AHO` at edge t to the tally: updated at t+1.
- Latency to `OVF`: same edge as the wrap.
- Latency to the display: `AHO` reaches `SEG` at the first 3→0 `idx` transition after t+1. Worst case is 4·SCAN_DIV cycles plus 1.
- After reset release, the first `idx` advance occurs SCAN_DIV cycles later, and the first snapshot load occurs 4·SCAN_DIV cycles later.
- Reset asserted mid-frame: the next edge forces all reset values, including `sc`=0 and `idx`=0. No partial frame is resumed.
- `CLR` does not touch `sc`, `idx` or `snap`. The display shows the old value until the next snapshot.
- `AHO` held high continuously counts once per cycle.

## Structure
- Shared package `aho_pkg` holds:
  - the BCD digit type (4 bits)
  - the digit count (4)
  - the active-low segment constants `SEG_0..SEG_9`
  - `SEG_OFF` = 1111111
- Sub-module `bcd_to_seg7`: a combinational 4-bit BCD to 7-bit active-low decoder. Inputs 10..15 output `SEG_OFF`.
- Top-level contents:
  - BCD carry chain
  - `OVF` logic
  - scan divider
  - `idx` counter
  - snapshot register
  - digit mux

## Test plan
Use SCAN_DIV=4 in simulation.
- Reset: `RST`=0 for 2 cycles, then released.
  - Required: `DIG`=1110, `SEG`=1000000, `OVF`=0.
  - `DIG` stays 1110 for 4 cycles, then becomes 1101.
- Count and display: `AHO` high for 12 consecutive cycles, then wait 2 frames.
  - Required: tally 0012.
  - Digit 0 shows `SEG`=0100100 and digit 1 shows `SEG`=1111001, with `DIG`=1101 during digit 1.
  - Digits 2 and 3 show 1000000.
- Carry chain: 99 `AHO` cycles.
  - Required: tally 0099.
  - One more `AHO` cycle gives 0100 on the next edge.
- Overflow: 10000 `AHO` cycles.
  - Required: tally 0000 and `OVF`=1.
  - 5 more gives 0005 with `OVF` still 1.
- Clear priority: tally 0042 with `OVF`=1, then `CLR`=1 and `AHO`=1 in the same cycle.
  - Required: tally 0000 and `OVF`=0 next cycle.
  - The snapshot still shows 0042 until the next frame start.
- Reset mid-frame: `RST`=0 for one cycle while `idx`=2 and the tally is 0307.
  - Required on the next edge: `DIG`=1110, `SEG`=1000000, `sc`=0, tally 0000, and `snap`=0000.
